// File: rtl/core.sv
`default_nettype none
// ==========================================================================
// core : 5-stage in-order MIPS-I subset pipeline without forwarding or stalls
// Revision: 1.0
// ==========================================================================
module core (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] read_instruction,
  input  logic [31:0] read_data,
  output logic [31:0] instruction_address,
  output logic [31:0] data_address,
  output logic [31:0] write_data,
  output logic        mem_write,
  output logic        mem_read
);

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR, ALU_SLT, ALU_SLL, ALU_SRL
  } alu_op_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_XOR = 6'h26;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;

  // ---------------- IF ----------------
  logic [31:0] pc_q, pc_d;
  logic [31:0] ifid_instr_q;

  assign pc_d = pc_q + 32'd4;

  // A cleared instruction register is the all-zero NOP, i.e. a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q         <= '0;
      ifid_instr_q <= '0;
    end else begin
      pc_q         <= pc_d;
      ifid_instr_q <= read_instruction;
    end
  end

  assign instruction_address = pc_q;

  // ---------------- ID ----------------
  logic [5:0]  id_op, id_funct;
  logic [4:0]  id_rs, id_rt, id_rd, id_shamt;
  logic [15:0] id_imm;

  assign {id_op, id_rs, id_rt, id_rd, id_shamt, id_funct} = ifid_instr_q;
  assign id_imm = ifid_instr_q[15:0];

  logic        wb_we_q;
  logic [4:0]  wb_rd_q;
  logic [31:0] wb_val_q;
  logic [31:0] rf_q [32];
  logic [31:0] id_rs_val, id_rt_val;

  // A write retiring this cycle is visible to the reader in ID immediately.
  always_comb begin
    id_rs_val = rf_q[id_rs];
    id_rt_val = rf_q[id_rt];
    if (wb_we_q && (wb_rd_q == id_rs) && (id_rs != 5'd0)) id_rs_val = wb_val_q;
    if (wb_we_q && (wb_rd_q == id_rt) && (id_rt != 5'd0)) id_rt_val = wb_val_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else if (wb_we_q && (wb_rd_q != 5'd0)) begin
      rf_q[wb_rd_q] <= wb_val_q;
    end
  end

  alu_op_e     id_alu_op;
  logic        id_use_imm, id_zext, id_reg_write, id_mem_read, id_mem_write;
  logic [4:0]  id_dest;
  logic [31:0] id_imm_ext;

  always_comb begin
    id_alu_op    = ALU_ADD;
    id_use_imm   = 1'b0;
    id_zext      = 1'b0;
    id_dest      = id_rt;
    id_reg_write = 1'b0;
    id_mem_read  = 1'b0;
    id_mem_write = 1'b0;
    case (id_op)
      OP_RTYPE: begin
        id_dest      = id_rd;
        id_reg_write = 1'b1;
        case (id_funct)
          FN_ADD:  id_alu_op = ALU_ADD;
          FN_SUB:  id_alu_op = ALU_SUB;
          FN_AND:  id_alu_op = ALU_AND;
          FN_OR:   id_alu_op = ALU_OR;
          FN_XOR:  id_alu_op = ALU_XOR;
          FN_NOR:  id_alu_op = ALU_NOR;
          FN_SLT:  id_alu_op = ALU_SLT;
          FN_SLL:  id_alu_op = ALU_SLL;
          FN_SRL:  id_alu_op = ALU_SRL;
          default: id_reg_write = 1'b0;
        endcase
      end
      OP_ADDI: begin id_alu_op = ALU_ADD; id_use_imm = 1'b1; id_reg_write = 1'b1; end
      OP_SLTI: begin id_alu_op = ALU_SLT; id_use_imm = 1'b1; id_reg_write = 1'b1; end
      OP_ANDI: begin id_alu_op = ALU_AND; id_use_imm = 1'b1; id_zext = 1'b1; id_reg_write = 1'b1; end
      OP_ORI:  begin id_alu_op = ALU_OR;  id_use_imm = 1'b1; id_zext = 1'b1; id_reg_write = 1'b1; end
      OP_XORI: begin id_alu_op = ALU_XOR; id_use_imm = 1'b1; id_zext = 1'b1; id_reg_write = 1'b1; end
      OP_LW:   begin id_use_imm = 1'b1; id_reg_write = 1'b1; id_mem_read = 1'b1; end
      OP_SW:   begin id_use_imm = 1'b1; id_mem_write = 1'b1; end
      default: ;
    endcase
  end

  assign id_imm_ext = id_zext ? {16'h0000, id_imm} : {{16{id_imm[15]}}, id_imm};

  alu_op_e     idex_alu_op_q;
  logic [31:0] idex_a_q, idex_b_q, idex_rt_q;
  logic [4:0]  idex_shamt_q, idex_dest_q;
  logic        idex_reg_write_q, idex_mem_read_q, idex_mem_write_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idex_alu_op_q    <= ALU_ADD;
      idex_a_q         <= '0;
      idex_b_q         <= '0;
      idex_rt_q        <= '0;
      idex_shamt_q     <= '0;
      idex_dest_q      <= '0;
      idex_reg_write_q <= 1'b0;
      idex_mem_read_q  <= 1'b0;
      idex_mem_write_q <= 1'b0;
    end else begin
      idex_alu_op_q    <= id_alu_op;
      idex_a_q         <= id_rs_val;
      idex_b_q         <= id_use_imm ? id_imm_ext : id_rt_val;
      idex_rt_q        <= id_rt_val;
      idex_shamt_q     <= id_shamt;
      idex_dest_q      <= id_dest;
      idex_reg_write_q <= id_reg_write && (id_dest != 5'd0);
      idex_mem_read_q  <= id_mem_read;
      idex_mem_write_q <= id_mem_write;
    end
  end

  // ---------------- EX ----------------
  logic [31:0] ex_result;

  always_comb begin
    ex_result = idex_a_q + idex_b_q;
    case (idex_alu_op_q)
      ALU_SUB: ex_result = idex_a_q - idex_b_q;
      ALU_AND: ex_result = idex_a_q & idex_b_q;
      ALU_OR:  ex_result = idex_a_q | idex_b_q;
      ALU_XOR: ex_result = idex_a_q ^ idex_b_q;
      ALU_NOR: ex_result = ~(idex_a_q | idex_b_q);
      ALU_SLT: ex_result = {31'd0, ($signed(idex_a_q) < $signed(idex_b_q))};
      ALU_SLL: ex_result = idex_rt_q << idex_shamt_q;
      ALU_SRL: ex_result = idex_rt_q >> idex_shamt_q;
      default: ;
    endcase
  end

  logic [31:0] exmem_result_q, exmem_store_q;
  logic [4:0]  exmem_dest_q;
  logic        exmem_reg_write_q, exmem_mem_read_q, exmem_mem_write_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exmem_result_q    <= '0;
      exmem_store_q     <= '0;
      exmem_dest_q      <= '0;
      exmem_reg_write_q <= 1'b0;
      exmem_mem_read_q  <= 1'b0;
      exmem_mem_write_q <= 1'b0;
    end else begin
      exmem_result_q    <= ex_result;
      exmem_store_q     <= idex_rt_q;
      exmem_dest_q      <= idex_dest_q;
      exmem_reg_write_q <= idex_reg_write_q;
      exmem_mem_read_q  <= idex_mem_read_q;
      exmem_mem_write_q <= idex_mem_write_q;
    end
  end

  // ---------------- MEM ----------------
  assign data_address = exmem_result_q;
  assign write_data   = exmem_store_q;
  assign mem_read     = exmem_mem_read_q;
  assign mem_write    = exmem_mem_write_q;

  logic [31:0] wb_val_d;
  assign wb_val_d = exmem_mem_read_q ? read_data : exmem_result_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_we_q  <= 1'b0;
      wb_rd_q  <= '0;
      wb_val_q <= '0;
    end else begin
      wb_we_q  <= exmem_reg_write_q;
      wb_rd_q  <= exmem_dest_q;
      wb_val_q <= wb_val_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_core.sv
`default_nettype none
// ==========================================================================
// tb_core : directed and random programs checked against an instruction-level model
// Revision: 1.0
// ==========================================================================
module tb_core;

  logic        clk;
  logic        rst_n;
  logic [31:0] read_instruction, read_data;
  logic [31:0] instruction_address, data_address, write_data;
  logic        mem_write, mem_read;

  core dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .read_instruction    (read_instruction),
    .read_data           (read_data),
    .instruction_address (instruction_address),
    .data_address        (data_address),
    .write_data          (write_data),
    .mem_write           (mem_write),
    .mem_read            (mem_read)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] imem [1024];
  logic [31:0] dmem [64];

  assign read_instruction = imem[instruction_address[11:2]];
  assign read_data        = dmem[data_address[7:2]];

  // Architectural model state and per-instruction expected MEM-stage activity
  logic [31:0] m_reg [32];
  logic [31:0] m_mem [64];
  logic        exp_rd [1024];
  logic        exp_wr [1024];
  logic [31:0] exp_addr [1024];
  logic [31:0] exp_wdata [1024];

  int n_checks = 0;
  int n_errors = 0;
  int prog_len = 0;

  logic [31:0] ka_r [11];
  logic [31:0] ka_i [7];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [5:0] fn, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [4:0] rd,
                                        input logic [4:0] sh);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic emit(input logic [31:0] ins);
    imem[prog_len] = ins;
    prog_len++;
  endtask

  task automatic nops(input int n);
    repeat (n) emit(32'h0);
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 1024; i++) imem[i] = 32'h0;
    prog_len = 0;
  endtask

  // Executes the program one instruction at a time, in order.
  task automatic model_run();
    for (int r = 0; r < 32; r++) m_reg[r] = 32'h0;
    for (int a = 0; a < 64; a++) m_mem[a] = dmem[a];
    for (int k = 0; k < prog_len; k++) begin
      logic [31:0] ins, s, t, res, addr, simm, zimm;
      logic        wr;
      logic [4:0]  dst;
      ins  = imem[k];
      s    = m_reg[ins[25:21]];
      t    = m_reg[ins[20:16]];
      simm = {{16{ins[15]}}, ins[15:0]};
      zimm = {16'h0000, ins[15:0]};
      addr = s + simm;
      wr   = 1'b0;
      dst  = ins[20:16];
      res  = 32'h0;
      exp_rd[k] = 1'b0; exp_wr[k] = 1'b0; exp_addr[k] = addr; exp_wdata[k] = t;
      case (ins[31:26])
        6'h00: begin
          dst = ins[15:11];
          wr  = 1'b1;
          case (ins[5:0])
            6'h20:   res = s + t;
            6'h22:   res = s - t;
            6'h24:   res = s & t;
            6'h25:   res = s | t;
            6'h26:   res = s ^ t;
            6'h27:   res = ~(s | t);
            6'h2A:   res = ($signed(s) < $signed(t)) ? 32'd1 : 32'd0;
            6'h00:   res = t << ins[10:6];
            6'h02:   res = t >> ins[10:6];
            default: wr = 1'b0;
          endcase
        end
        6'h08: begin wr = 1'b1; res = s + simm; end
        6'h0A: begin wr = 1'b1; res = ($signed(s) < $signed(simm)) ? 32'd1 : 32'd0; end
        6'h0C: begin wr = 1'b1; res = s & zimm; end
        6'h0D: begin wr = 1'b1; res = s | zimm; end
        6'h0E: begin wr = 1'b1; res = s ^ zimm; end
        6'h23: begin wr = 1'b1; exp_rd[k] = 1'b1; res = m_mem[addr[7:2]]; end
        6'h2B: begin exp_wr[k] = 1'b1; m_mem[addr[7:2]] = t; end
        default: ;
      endcase
      if (wr && dst != 5'd0) m_reg[dst] = res;
    end
  endtask

  // Resets the core asynchronously mid-cycle, then runs and checks every cycle.
  task automatic run_prog(input int cycles);
    model_run();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_pc", instruction_address, 32'h0);
    check("rst_mem_read", {31'd0, mem_read}, 32'h0);
    check("rst_mem_write", {31'd0, mem_write}, 32'h0);
    check("rst_daddr", data_address, 32'h0);
    check("rst_wdata", write_data, 32'h0);
    @(posedge clk);
    #1 check("rst_hold_pc", instruction_address, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int e = 1; e <= cycles; e++) begin
      int   k;
      logic er, ew;
      @(negedge clk);
      check($sformatf("pc@%0d", e), instruction_address, 32'(4 * e));
      k = e - 3;
      if (k >= 0 && k < prog_len) begin
        er = exp_rd[k];
        ew = exp_wr[k];
      end else begin
        er = 1'b0;
        ew = 1'b0;
      end
      check($sformatf("mem_read@%0d", e), {31'd0, mem_read}, {31'd0, er});
      check($sformatf("mem_write@%0d", e), {31'd0, mem_write}, {31'd0, ew});
      if (er || ew) check($sformatf("daddr@%0d", e), data_address, exp_addr[k]);
      if (ew) check($sformatf("wdata@%0d", e), write_data, exp_wdata[k]);
      if (mem_write) dmem[data_address[7:2]] = write_data;
    end
  endtask

  // Random program; any source written by one of the previous 3 instructions becomes a NOP.
  task automatic gen_random(input int n);
    logic [4:0] recent [3];
    for (int i = 0; i < 3; i++) recent[i] = 5'd0;
    for (int j = 0; j < n; j++) begin
      int          kind;
      logic [4:0]  rs, rt, rd, dst;
      logic [5:0]  sel;
      logic [15:0] imm;
      logic [31:0] ins;
      logic        use_rs, use_rt, conflict;
      kind = int'($urandom_range(0, 17));
      rs   = 5'($urandom_range(0, 31));
      rt   = 5'($urandom_range(0, 31));
      rd   = 5'($urandom_range(0, 31));
      imm  = 16'($urandom);
      dst  = 5'd0; use_rs = 1'b0; use_rt = 1'b0;
      if (kind < 9) begin
        case (kind)
          0: sel = 6'h20; 1: sel = 6'h22; 2: sel = 6'h24; 3: sel = 6'h25; 4: sel = 6'h26;
          5: sel = 6'h27; 6: sel = 6'h2A; 7: sel = 6'h00; default: sel = 6'h02;
        endcase
        ins = enc_r(sel, rs, rt, rd, 5'($urandom));
        dst = rd; use_rs = 1'b1; use_rt = 1'b1;
      end else if (kind < 14) begin
        case (kind)
          9: sel = 6'h08; 10: sel = 6'h0A; 11: sel = 6'h0C; 12: sel = 6'h0D; default: sel = 6'h0E;
        endcase
        ins = enc_i(sel, rs, rt, imm);
        dst = rt; use_rs = 1'b1;
      end else if (kind == 14) begin
        ins = enc_i(6'h23, rs, rt, imm);
        dst = rt; use_rs = 1'b1;
      end else if (kind == 15) begin
        ins = enc_i(6'h2B, rs, rt, imm);
        use_rs = 1'b1; use_rt = 1'b1;
      end else if (kind == 16) begin
        ins = enc_r(6'h21, rs, rt, rd, 5'd0);
      end else begin
        case ($urandom_range(0, 3))
          0: sel = 6'h01; 1: sel = 6'h04; 2: sel = 6'h0F; default: sel = 6'h3F;
        endcase
        ins = enc_i(sel, rs, rt, imm);
      end
      conflict = 1'b0;
      for (int r = 0; r < 3; r++) begin
        if (use_rs && rs != 5'd0 && rs == recent[r]) conflict = 1'b1;
        if (use_rt && rt != 5'd0 && rt == recent[r]) conflict = 1'b1;
      end
      if (conflict) begin
        ins = 32'h0;
        dst = 5'd0;
      end
      emit(ins);
      recent[2] = recent[1];
      recent[1] = recent[0];
      recent[0] = dst;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    ka_r = '{32'd3, 32'd3, 32'd0, 32'd1, 32'd4, 32'd0, 32'd1, 32'hFFFFFFFC, 32'd3, 32'd1, 32'hFFFFFFFF};
    ka_i = '{32'd3, 32'd0, 32'd3, 32'd3, 32'd1, 32'd1, 32'h0000FFFF};

    // Directed program
    for (int a = 0; a < 64; a++) dmem[a] = 32'hDEADBEEF;
    dmem[0] = 32'd8;
    dmem[1] = 32'd100;
    clear_prog();
    emit(enc_i(6'h23, 5'd0, 5'd2, 16'h0000));
    emit(enc_i(6'h23, 5'd0, 5'd3, 16'h0004));
    nops(6);
    emit(enc_i(6'h2B, 5'd2, 5'd3, 16'h0000));
    emit(enc_i(6'h08, 5'd0, 5'd8, 16'h0001));
    emit(enc_i(6'h08, 5'd0, 5'd9, 16'h0002));
    nops(6);
    emit(enc_r(6'h20, 5'd8, 5'd9, 5'd16, 5'd0));
    emit(enc_r(6'h25, 5'd8, 5'd9, 5'd17, 5'd0));
    emit(enc_r(6'h24, 5'd8, 5'd9, 5'd18, 5'd0));
    emit(enc_r(6'h02, 5'd0, 5'd9, 5'd19, 5'd1));
    emit(enc_r(6'h00, 5'd0, 5'd9, 5'd20, 5'd1));
    emit(enc_r(6'h2A, 5'd9, 5'd8, 5'd21, 5'd0));
    emit(enc_r(6'h2A, 5'd8, 5'd9, 5'd22, 5'd0));
    emit(enc_r(6'h27, 5'd8, 5'd9, 5'd23, 5'd0));
    emit(enc_r(6'h26, 5'd8, 5'd9, 5'd24, 5'd0));
    emit(enc_r(6'h22, 5'd9, 5'd8, 5'd25, 5'd0));
    emit(enc_r(6'h22, 5'd8, 5'd9, 5'd26, 5'd0));
    emit(enc_i(6'h08, 5'd9, 5'd10, 16'h0001));
    emit(enc_i(6'h0C, 5'd9, 5'd11, 16'h0001));
    emit(enc_i(6'h0D, 5'd9, 5'd12, 16'h0001));
    emit(enc_i(6'h0E, 5'd9, 5'd13, 16'h0001));
    emit(enc_i(6'h0A, 5'd9, 5'd14, 16'h0004));
    emit(enc_i(6'h08, 5'd9, 5'd15, 16'hFFFF));
    emit(enc_i(6'h0D, 5'd0, 5'd4, 16'hFFFF));
    emit(enc_i(6'h08, 5'd0, 5'd0, 16'h0005));
    emit(enc_i(6'h3F, 5'd0, 5'd5, 16'h0007));
    emit(enc_i(6'h23, 5'd0, 5'd6, 16'h0004));
    nops(3);
    emit(enc_i(6'h08, 5'd6, 5'd7, 16'h0001));
    nops(3);
    for (int i = 0; i < 11; i++) emit(enc_i(6'h2B, 5'd0, 5'(16 + i), 16'(16'h0040 + 4 * i)));
    for (int i = 0; i < 6; i++)  emit(enc_i(6'h2B, 5'd0, 5'(10 + i), 16'(16'h0080 + 4 * i)));
    emit(enc_i(6'h2B, 5'd0, 5'd4, 16'h0098));
    emit(enc_i(6'h2B, 5'd0, 5'd0, 16'h0020));
    emit(enc_i(6'h2B, 5'd0, 5'd5, 16'h0024));
    emit(enc_i(6'h2B, 5'd0, 5'd7, 16'h0028));
    run_prog(prog_len + 3);

    check("ka_sw_ldval", dmem[2], 32'd100);
    for (int i = 0; i < 11; i++) check($sformatf("ka_r%0d", i), dmem[16 + i], ka_r[i]);
    for (int i = 0; i < 7; i++)  check($sformatf("ka_i%0d", i), dmem[32 + i], ka_i[i]);
    check("ka_r0_store", dmem[8], 32'd0);
    check("ka_unsupported", dmem[9], 32'd0);
    check("ka_hazard", dmem[10], 32'd101);

    // Random programs; run 1 is cut short so the next reset lands mid-flight
    for (int run = 0; run < 4; run++) begin
      for (int a = 0; a < 64; a++) dmem[a] = $urandom;
      clear_prog();
      gen_random(150);
      run_prog((run == 1) ? 60 : prog_len + 3);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
